// File: rtl/adpll_pkg.sv
// adpll_pkg
//   Shared definitions for the ADPLL loop controller: FSM state encoding,
//   PFD decision encoding, default widths/timing constants and the helper
//   that turns the raw PFD flag pair into a decision.
package adpll_pkg;

  localparam int COARSE_W_DEF = 3;
  localparam int FINE_W_DEF   = 6;
  localparam int SETTLE_DEF   = 4;
  localparam int LOCK_N_DEF   = 4;
  localparam int UNLOCK_N_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_C_SAR  = 3'd1,
    ST_F_SAR  = 3'd2,
    ST_TRACK  = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  // DEC_HOLD doubles as "no previous direction" in the tracking logic.
  typedef enum logic [1:0] {
    DEC_HOLD = 2'd0,
    DEC_UP   = 2'd1,
    DEC_DN   = 2'd2
  } dec_e;

  // Only an unambiguous flag is a decision; both-or-neither is HOLD.
  function automatic dec_e decode_pfd(input logic up, input logic dn);
    if (up && !dn) begin
      return DEC_UP;
    end else if (dn && !up) begin
      return DEC_DN;
    end else begin
      return DEC_HOLD;
    end
  endfunction

endpackage

// File: rtl/adpll_sar_step.sv
// adpll_sar_step
//   One successive-approximation step on a DCO code field (combinational).
//   The bit at idx_i is the trial bit, already set: a DN decision clears it,
//   UP/HOLD keeps it. The next lower bit (if any) is set for the next trial.
// Ports:
//   code_i  current code
//   idx_i   trial bit index (0 = LSB)
//   dec_i   PFD decision for this window
//   code_o  code after the step
module adpll_sar_step
  import adpll_pkg::*;
#(
  parameter int W  = 3,
  parameter int IW = 3
) (
  input  logic [W-1:0]  code_i,
  input  logic [IW-1:0] idx_i,
  input  dec_e          dec_i,
  output logic [W-1:0]  code_o
);

  logic keep_trial;
  assign keep_trial = (dec_i != DEC_DN);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    if (gi == W - 1) begin : g_msb
      // The MSB is never the "next lower" bit of anything.
      assign code_o[gi] = (idx_i == IW'(gi)) ? (keep_trial & code_i[gi]) : code_i[gi];
    end else begin : g_low
      assign code_o[gi] = (idx_i == IW'(gi))     ? (keep_trial & code_i[gi]) :
                          (idx_i == IW'(gi + 1)) ? 1'b1 : code_i[gi];
    end
  end

endmodule

// File: rtl/adpll_lock_ctrl.sv
// adpll_lock_ctrl
//   ADPLL loop controller. Turns PFD up/down decisions into DCO codes:
//   SAR search on the coarse code, SAR search on the fine code, then linear
//   tracking of the fine code with lock/unlock detection.
// Ports:
//   REF_CLK    reference clock, rising edge
//   RESET_     asynchronous active-low reset
//   enable     run the loop; low forces IDLE
//   pfd_up     PFD up flag (DCO slow), synchronous to REF_CLK
//   pfd_dn     PFD down flag (DCO fast), synchronous to REF_CLK
//   coarse     coarse DCO code (registered)
//   fine       fine DCO code (registered)
//   freq_lock  lock indicator (registered)
//   state      current FSM state, debug
module adpll_lock_ctrl
  import adpll_pkg::*;
#(
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int FINE_W   = FINE_W_DEF,
  parameter int SETTLE   = SETTLE_DEF,
  parameter int LOCK_N   = LOCK_N_DEF,
  parameter int UNLOCK_N = UNLOCK_N_DEF
) (
  input  logic                REF_CLK,
  input  logic                RESET_,
  input  logic                enable,
  input  logic                pfd_up,
  input  logic                pfd_dn,
  output logic [COARSE_W-1:0] coarse,
  output logic [FINE_W-1:0]   fine,
  output logic                freq_lock,
  output logic [2:0]          state
);

  localparam int MAXW  = (COARSE_W > FINE_W) ? COARSE_W : FINE_W;
  localparam int IDX_W = $clog2(MAXW);
  localparam int SW    = $clog2(SETTLE);
  localparam int RW    = $clog2(LOCK_N + 1);
  localparam int UW    = $clog2(UNLOCK_N + 1);

  localparam logic [COARSE_W-1:0] MID_C = {1'b1, {(COARSE_W-1){1'b0}}};
  localparam logic [FINE_W-1:0]   MID_F = {1'b1, {(FINE_W-1){1'b0}}};

  state_e              state_q, state_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [FINE_W-1:0]   fine_q, fine_d;
  logic                lock_q, lock_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [RW-1:0]       rev_q, rev_d;
  logic [UW-1:0]       run_q, run_d;
  dec_e                prev_q, prev_d;

  // ---------------------------------------------------------------------------
  // Decision sampling: one decision per settle window, on its last cycle.
  // ---------------------------------------------------------------------------
  logic sample;
  dec_e dec;
  logic step_up, step_dn;

  assign sample  = (settle_q == SW'(SETTLE - 1));
  assign dec     = decode_pfd(pfd_up, pfd_dn);
  assign step_up = sample && (dec == DEC_UP);
  assign step_dn = sample && (dec == DEC_DN);

  // SAR helpers, one per code field; each result is only used in its phase.
  logic [COARSE_W-1:0] coarse_sar;
  logic [FINE_W-1:0]   fine_sar;

  adpll_sar_step #(.W(COARSE_W), .IW(IDX_W)) u_sar_coarse (
    .code_i (coarse_q),
    .idx_i  (bit_idx_q),
    .dec_i  (dec),
    .code_o (coarse_sar)
  );

  adpll_sar_step #(.W(FINE_W), .IW(IDX_W)) u_sar_fine (
    .code_i (fine_q),
    .idx_i  (bit_idx_q),
    .dec_i  (dec),
    .code_o (fine_sar)
  );

  // ---------------------------------------------------------------------------
  // Tracking bookkeeping: saturation, reversal and run counting.
  // ---------------------------------------------------------------------------
  logic          sat_hit, reversal, same_dir, lock_hit, unlock_hit;
  logic [RW-1:0] rev_inc, rev_step;
  logic [UW-1:0] run_inc, run_step;

  assign sat_hit  = (step_up && (&fine_q)) || (step_dn && ~(|fine_q));
  assign reversal = (step_up && prev_q == DEC_DN) || (step_dn && prev_q == DEC_UP);
  assign same_dir = (step_up && prev_q == DEC_UP) || (step_dn && prev_q == DEC_DN);

  // Both counters saturate so long dithering or long runs cannot wrap.
  assign rev_inc  = (rev_q == RW'(LOCK_N))   ? rev_q : rev_q + RW'(1);
  assign run_inc  = (run_q == UW'(UNLOCK_N)) ? run_q : run_q + UW'(1);
  assign rev_step = reversal ? rev_inc : (same_dir ? '0 : rev_q);
  // A reversal or the very first step both start a new run of length 1.
  assign run_step = same_dir ? run_inc : UW'(1);

  assign lock_hit   = reversal && (rev_step == RW'(LOCK_N));
  assign unlock_hit = same_dir && (run_step == UW'(UNLOCK_N));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge REF_CLK or negedge RESET_) begin
    if (!RESET_) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_C_SAR;
        ST_C_SAR:  if (sample && bit_idx_q == '0) state_d = ST_F_SAR;
        ST_F_SAR:  if (sample && bit_idx_q == '0) state_d = ST_TRACK;
        ST_TRACK: begin
          if (sat_hit) begin
            state_d = ST_C_SAR;
          end else if (lock_hit) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: if (unlock_hit) state_d = ST_TRACK;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    coarse_d  = coarse_q;
    fine_d    = fine_q;
    lock_d    = lock_q;
    settle_d  = sample ? '0 : settle_q + SW'(1);
    bit_idx_d = bit_idx_q;
    rev_d     = rev_q;
    run_d     = run_q;
    prev_d    = prev_q;

    if (!enable || state_q == ST_IDLE) begin
      coarse_d  = MID_C;
      fine_d    = MID_F;
      lock_d    = 1'b0;
      settle_d  = '0;
      rev_d     = '0;
      run_d     = '0;
      prev_d    = DEC_HOLD;
      // Leaving IDLE: the coarse MSB is the first trial bit.
      bit_idx_d = enable ? IDX_W'(COARSE_W - 1) : '0;
    end else begin
      case (state_q)
        ST_C_SAR: begin
          if (sample) begin
            coarse_d = coarse_sar;
            if (bit_idx_q == '0) begin
              bit_idx_d = IDX_W'(FINE_W - 1);
              fine_d    = MID_F;
            end else begin
              bit_idx_d = bit_idx_q - IDX_W'(1);
            end
          end
        end
        ST_F_SAR: begin
          if (sample) begin
            fine_d = fine_sar;
            if (bit_idx_q != '0) begin
              bit_idx_d = bit_idx_q - IDX_W'(1);
            end
          end
        end
        ST_TRACK, ST_LOCKED: begin
          if (step_up || step_dn) begin
            if (sat_hit && state_q == ST_TRACK) begin
              // Ran off the end of the fine range: the coarse pick was wrong.
              coarse_d  = MID_C;
              fine_d    = MID_F;
              bit_idx_d = IDX_W'(COARSE_W - 1);
              rev_d     = '0;
              run_d     = '0;
              prev_d    = DEC_HOLD;
            end else begin
              // In LOCKED a step into a limit just saturates.
              if (!sat_hit) begin
                fine_d = step_up ? fine_q + FINE_W'(1) : fine_q - FINE_W'(1);
              end
              prev_d = dec;
              rev_d  = rev_step;
              run_d  = run_step;
              if (state_q == ST_TRACK && lock_hit) begin
                lock_d = 1'b1;
              end
              if (state_q == ST_LOCKED && unlock_hit) begin
                lock_d = 1'b0;
                rev_d  = '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge REF_CLK or negedge RESET_) begin
    if (!RESET_) begin
      coarse_q  <= MID_C;
      fine_q    <= MID_F;
      lock_q    <= 1'b0;
      settle_q  <= '0;
      bit_idx_q <= '0;
      rev_q     <= '0;
      run_q     <= '0;
      prev_q    <= DEC_HOLD;
    end else begin
      coarse_q  <= coarse_d;
      fine_q    <= fine_d;
      lock_q    <= lock_d;
      settle_q  <= settle_d;
      bit_idx_q <= bit_idx_d;
      rev_q     <= rev_d;
      run_q     <= run_d;
      prev_q    <= prev_d;
    end
  end

  assign coarse    = coarse_q;
  assign fine      = fine_q;
  assign freq_lock = lock_q;
  assign state     = state_q;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// tb_adpll_lock_ctrl
//   Directed bench for adpll_lock_ctrl (default parameters). Stimulus pushes
//   hand-computed expected outputs, tagged with the cycle they are due, into
//   a queue; an independent monitor pops and compares on the falling edge.
module tb_adpll_lock_ctrl;

  logic       REF_CLK = 1'b0;
  logic       RESET_;
  logic       enable;
  logic       pfd_up;
  logic       pfd_dn;
  logic [2:0] coarse;
  logic [5:0] fine;
  logic       freq_lock;
  logic [2:0] state;

  adpll_lock_ctrl dut (
    .REF_CLK   (REF_CLK),
    .RESET_    (RESET_),
    .enable    (enable),
    .pfd_up    (pfd_up),
    .pfd_dn    (pfd_dn),
    .coarse    (coarse),
    .fine      (fine),
    .freq_lock (freq_lock),
    .state     (state)
  );

  always #5 REF_CLK = ~REF_CLK;

  int unsigned cycle_cnt = 0;
  always @(posedge REF_CLK) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [2:0]  c;
    logic [5:0]  f;
    logic        l;
    logic [2:0]  s;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Expected outputs due at the falling edge 'delay' cycles from now.
  task automatic push_exp(input string name, input logic [2:0] c, input logic [5:0] f,
                          input logic l, input logic [2:0] s, input int unsigned delay = 0);
    exp_t e;
    e.cyc  = cycle_cnt + delay;
    e.name = name;
    e.c    = c;
    e.f    = f;
    e.l    = l;
    e.s    = s;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge REF_CLK);
    #1;
  endtask

  // One decision window: flags held for SETTLE=4 cycles, ends just after the
  // deciding edge.
  task automatic decide(input logic up, input logic dn);
    pfd_up = up;
    pfd_dn = dn;
    tick(4);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge REF_CLK);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle_cnt) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (coarse !== mon_e.c || fine !== mon_e.f || freq_lock !== mon_e.l || state !== mon_e.s) begin
          errors++;
          $display("FAIL %s @%0d: coarse=%0d fine=%0d lock=%0b state=%0d, expected coarse=%0d fine=%0d lock=%0b state=%0d",
                   mon_e.name, cycle_cnt, coarse, fine, freq_lock, state,
                   mon_e.c, mon_e.f, mon_e.l, mon_e.s);
        end else begin
          $display("ok   %s @%0d: coarse=%0d fine=%0d lock=%0b state=%0d",
                   mon_e.name, cycle_cnt, coarse, fine, freq_lock, state);
        end
      end
    end
  end

  logic [5:0] up_fine [6] = '{6'd48, 6'd56, 6'd60, 6'd62, 6'd63, 6'd63};
  logic [5:0] dn_fine [6] = '{6'd16, 6'd8, 6'd4, 6'd2, 6'd1, 6'd0};
  logic [2:0] up_crs  [3] = '{3'd6, 3'd7, 3'd7};
  logic [2:0] dn_crs  [3] = '{3'd2, 3'd1, 3'd0};

  // Stimulus
  initial begin
    RESET_ = 1'b0;
    enable = 1'b0;
    pfd_up = 1'b0;
    pfd_dn = 1'b0;

    // Reset and idle with enable low.
    tick(2);
    push_exp("reset_hold", 3'd4, 6'd32, 1'b0, 3'd0);
    tick(1);
    RESET_ = 1'b1;
    push_exp("idle_0", 3'd4, 6'd32, 1'b0, 3'd0, 0);
    push_exp("idle_10", 3'd4, 6'd32, 1'b0, 3'd0, 10);
    push_exp("idle_20", 3'd4, 6'd32, 1'b0, 3'd0, 20);
    tick(21);

    // Constant UP: coarse 4->6->7, fine to 63, then restart on saturation.
    enable = 1'b1;
    pfd_up = 1'b1;
    tick(1);
    push_exp("up_csar_entry", 3'd4, 6'd32, 1'b0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      decide(1'b1, 1'b0);
      push_exp($sformatf("up_coarse%0d", i), up_crs[i], 6'd32, 1'b0, (i == 2) ? 3'd2 : 3'd1);
    end
    for (int i = 0; i < 6; i++) begin
      decide(1'b1, 1'b0);
      push_exp($sformatf("up_fine%0d", i), 3'd7, up_fine[i], 1'b0, (i == 5) ? 3'd3 : 3'd2);
    end
    decide(1'b1, 1'b0);
    push_exp("up_restart", 3'd4, 6'd32, 1'b0, 3'd1);
    enable = 1'b0;
    pfd_up = 1'b0;
    tick(1);
    push_exp("up_disable", 3'd4, 6'd32, 1'b0, 3'd0);

    // Constant DN: coarse 4->2->1->0, fine to 0, then restart.
    enable = 1'b1;
    pfd_dn = 1'b1;
    tick(1);
    push_exp("dn_csar_entry", 3'd4, 6'd32, 1'b0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      decide(1'b0, 1'b1);
      push_exp($sformatf("dn_coarse%0d", i), dn_crs[i], 6'd32, 1'b0, (i == 2) ? 3'd2 : 3'd1);
    end
    for (int i = 0; i < 6; i++) begin
      decide(1'b0, 1'b1);
      push_exp($sformatf("dn_fine%0d", i), 3'd0, dn_fine[i], 1'b0, (i == 5) ? 3'd3 : 3'd2);
    end
    decide(1'b0, 1'b1);
    push_exp("dn_restart", 3'd4, 6'd32, 1'b0, 3'd1);
    enable = 1'b0;
    pfd_dn = 1'b0;
    tick(1);
    push_exp("dn_disable", 3'd4, 6'd32, 1'b0, 3'd0);

    // Lock: coarse UP,DN,UP -> 5; fine DN then UPs -> 31; then dither.
    enable = 1'b1;
    tick(1);
    decide(1'b1, 1'b0); push_exp("lk_c0", 3'd6, 6'd32, 1'b0, 3'd1);
    decide(1'b0, 1'b1); push_exp("lk_c1", 3'd5, 6'd32, 1'b0, 3'd1);
    decide(1'b1, 1'b0); push_exp("lk_c2", 3'd5, 6'd32, 1'b0, 3'd2);
    decide(1'b0, 1'b1); push_exp("lk_f0", 3'd5, 6'd16, 1'b0, 3'd2);
    decide(1'b1, 1'b0); push_exp("lk_f1", 3'd5, 6'd24, 1'b0, 3'd2);
    decide(1'b1, 1'b0); push_exp("lk_f2", 3'd5, 6'd28, 1'b0, 3'd2);
    decide(1'b1, 1'b0); push_exp("lk_f3", 3'd5, 6'd30, 1'b0, 3'd2);
    decide(1'b1, 1'b0); push_exp("lk_f4", 3'd5, 6'd31, 1'b0, 3'd2);
    decide(1'b1, 1'b0); push_exp("lk_f5", 3'd5, 6'd31, 1'b0, 3'd3);
    decide(1'b1, 1'b0); push_exp("lk_t0", 3'd5, 6'd32, 1'b0, 3'd3);
    decide(1'b0, 1'b1); push_exp("lk_rev1", 3'd5, 6'd31, 1'b0, 3'd3);
    decide(1'b1, 1'b0); push_exp("lk_rev2", 3'd5, 6'd32, 1'b0, 3'd3);
    decide(1'b0, 1'b1); push_exp("lk_rev3", 3'd5, 6'd31, 1'b0, 3'd3);
    decide(1'b1, 1'b0); push_exp("lk_rev4", 3'd5, 6'd32, 1'b1, 3'd4);
    decide(1'b1, 1'b1); push_exp("lk_hold", 3'd5, 6'd32, 1'b1, 3'd4);

    // Unlock: 8 consecutive DN; lock drops on the 8th.
    for (int i = 0; i < 8; i++) begin
      decide(1'b0, 1'b1);
      push_exp($sformatf("unlk_dn%0d", i + 1), 3'd5, 6'(31 - i),
               (i == 7) ? 1'b0 : 1'b1, (i == 7) ? 3'd3 : 3'd4);
    end

    // Relock from 24, then drop enable while LOCKED.
    decide(1'b1, 1'b0); push_exp("rlk_rev1", 3'd5, 6'd25, 1'b0, 3'd3);
    decide(1'b0, 1'b1); push_exp("rlk_rev2", 3'd5, 6'd24, 1'b0, 3'd3);
    decide(1'b1, 1'b0); push_exp("rlk_rev3", 3'd5, 6'd25, 1'b0, 3'd3);
    decide(1'b0, 1'b1); push_exp("rlk_rev4", 3'd5, 6'd24, 1'b1, 3'd4);
    enable = 1'b0;
    pfd_up = 1'b0;
    pfd_dn = 1'b0;
    tick(1);
    push_exp("lk_disable", 3'd4, 6'd32, 1'b0, 3'd0);

    // Asynchronous reset in the middle of F_SAR.
    enable = 1'b1;
    tick(1);
    decide(1'b1, 1'b0);
    decide(1'b1, 1'b0);
    decide(1'b1, 1'b0); push_exp("ar_fsar", 3'd7, 6'd32, 1'b0, 3'd2);
    decide(1'b1, 1'b0); push_exp("ar_fine0", 3'd7, 6'd48, 1'b0, 3'd2);
    tick(1);
    RESET_ = 1'b0;
    push_exp("ar_async", 3'd4, 6'd32, 1'b0, 3'd0);
    enable = 1'b0;
    pfd_up = 1'b0;
    tick(1);
    RESET_ = 1'b1;
    tick(2);
    push_exp("ar_idle", 3'd4, 6'd32, 1'b0, 3'd0);
    tick(2);

    if (exp_q.size() != 0) begin
      $display("FAIL leftover: %0d expected entries, 0 required", exp_q.size());
      errors += exp_q.size();
      checks += exp_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adpll_lock_ctrl.md
# adpll_lock_ctrl

Loop controller for the ADPLL: it turns PFD up/down decisions into DCO control codes. It runs a successive-approximation search on the coarse code, then on the fine code, then tracks the fine code linearly, and asserts `freq_lock` once the loop is dithering around the target. It sits between the PFD (`pfd_model`) and the DCO, and runs on the reference clock.

## Interface
- `COARSE_W`, default 3: coarse DCO code width.
- `FINE_W`, default 6: fine DCO code width.
- `SETTLE`, default 4: REF_CLK cycles the DCO settles per decision (≥2).
- `LOCK_N`, default 4: consecutive direction reversals needed to declare lock.
- `UNLOCK_N`, default 8: consecutive same-direction steps that drop lock.
- `REF_CLK` in 1: reference clock. All logic is on the rising edge.
- `RESET_` in 1: asynchronous, active-low reset.
- `enable` in 1: start/run the loop. Low forces IDLE.
- `pfd_up` in 1: PFD up flag (DCO slow or lagging), already synchronous to REF_CLK.
- `pfd_dn` in 1: PFD down flag (DCO fast or leading), already synchronous to REF_CLK.
- `coarse` out COARSE_W: coarse DCO code, registered.
- `fine` out FINE_W: fine DCO code, registered.
- `freq_lock` out 1: lock indicator, registered.
- `state` out 3: current FSM state, for debug.

## Operation
- States:
  - IDLE=0
  - C_SAR=1
  - F_SAR=2
  - TRACK=3
  - LOCKED=4
- Reset values:
  - `state` = IDLE.
  - `coarse` = 1 followed by zeros (mid-scale, 3'b100).
  - `fine` = mid-scale (6'b100000).
  - `freq_lock` = 0.
  - Internal settle, bit, reversal and run counters = 0.
- Decision sampling:
  - Flags are sampled once per window, on the cycle the settle counter equals SETTLE-1. The counter then wraps to 0.
  - Decision UP = `pfd_up & ~pfd_dn`.
  - Decision DN = `pfd_dn & ~pfd_up`.
  - Any other flag combination is HOLD.
- IDLE:
  - Codes are held at mid-scale.
  - `enable`=1 moves to C_SAR on the next edge; the settle counter starts at 0.
- C_SAR:
  - The trial bit index starts at the MSB, and the trial bit is already set.
  - On each decision, DN clears the trial bit; UP or HOLD keeps it.
  - The next lower bit is then set, in the same cycle.
  - After the LSB decision, go to F_SAR with `fine` at mid-scale.
- F_SAR:
  - Same algorithm as C_SAR, applied to `fine`.
  - After the LSB decision, go to TRACK.
- TRACK and LOCKED:
  - Per decision, UP adds 1 to `fine` and DN subtracts 1.
  - `fine` saturates at 0 and at 2^FINE_W-1. HOLD leaves it unchanged.
  - Reversal counter:
    - Increments when the current step direction is opposite to the previous non-HOLD step.
    - Resets to 0 on a same-direction step.
    - HOLD does not change it.
  - Run counter:
    - Counts consecutive same-direction steps.
    - Resets to 1 on a reversal.
  - TRACK → LOCKED, with `freq_lock`=1, on the decision that brings the reversal counter to LOCK_N.
  - LOCKED → TRACK, with `freq_lock`=0, on the decision that brings the run counter to UNLOCK_N. The reversal counter is cleared.
  - In TRACK (not LOCKED), a step attempted past a saturation limit restarts the search:
    - Go to C_SAR.
    - `coarse` and `fine` return to mid-scale.
    - Counters are cleared.
- `enable` falling in any state:
  - Next edge enters IDLE.
  - Codes return to mid-scale, `freq_lock`=0, counters are cleared.
- `RESET_` low mid-operation: all outputs and counters return to reset values immediately, with no wait for the clock.

## Timing
- All outputs are registered. A code update is visible one cycle after the deciding edge.
- C_SAR lasts COARSE_W×SETTLE cycles, and F_SAR lasts FINE_W×SETTLE cycles.
- With defaults, TRACK is entered 36 cycles after the IDLE→C_SAR edge.
- Lock is reached no earlier than LOCK_N×SETTLE cycles after TRACK entry.
- PFD flags must be stable for the sampling cycle. The block tolerates flags changing at any other time.

## Structure
- The shared package `adpll_pkg` holds:
  - the state enum encoding;
  - the decision enum (UP, DN, HOLD);
  - default widths and timing constants.
- Natural sub-module: `adpll_sar_step`, a combinational helper. Given the current code, the trial bit index and the decision, it returns the next code. It is instantiated once per code field (coarse and fine).
- The settle counter and lock and unlock counters stay in the top module.

## Test plan
All scenarios use default parameters.
- **Reset.** Hold RESET_=0 → `coarse`=4, `fine`=32, `freq_lock`=0, `state`=0. Release with `enable`=0 → outputs stay unchanged for 20 cycles.
- **Constant up.** `enable`=1, `pfd_up`=1 constantly → `coarse` steps 4→6→7, `fine` ends at 63 at cycle 36. In TRACK, the next UP step restarts the search: `state`=1, codes at mid-scale.
- **Constant down.** `pfd_dn`=1 constantly → `coarse` steps 4→2→1→0, and `fine` ends at 0. The next DN in TRACK restarts the search.
- **Lock.** After SAR, alternate UP and DN per decision window → `freq_lock` rises on the 4th reversal, and `fine` dithers between two adjacent values.
- **Unlock.** From LOCKED, apply 8 consecutive DN decisions → `freq_lock` falls on the 8th, `state`=3, and `fine` has dropped by 8.
- **Mid-operation reset and disable.**
  - Assert RESET_=0 asynchronously during F_SAR → reset values appear before the next clock edge.
  - Separately, drop `enable` in LOCKED → IDLE with codes at mid-scale on the next edge.
